// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD timer: FSM states, 7-segment patterns, prescaler divisor.
// Pure declarations; no latency or flow control.
package timer_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   // Active-high {dp,g,f,e,d,c,b,a}
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   function automatic int div_of(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to 7-segment pattern, dp always off; purely combinational, zero latency, no flow control.
module seg7_decoder
   import timer_pkg::*;
#(
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic [3:0] i_bcd,
   output logic [7:0] o_seg
);

   logic [7:0] w_pat;

   always_comb begin
      w_pat = SEG_BLANK;
      case (i_bcd)
         4'd0:    w_pat = SEG_0;
         4'd1:    w_pat = SEG_1;
         4'd2:    w_pat = SEG_2;
         4'd3:    w_pat = SEG_3;
         4'd4:    w_pat = SEG_4;
         4'd5:    w_pat = SEG_5;
         4'd6:    w_pat = SEG_6;
         4'd7:    w_pat = SEG_7;
         4'd8:    w_pat = SEG_8;
         4'd9:    w_pat = SEG_9;
         default: w_pat = SEG_BLANK;
      endcase
   end

   assign o_seg = (SEG_ACTIVE_LOW != 0) ? ~w_pat : w_pat;

endmodule

// File: rtl/bcd_timer_7seg.sv
// N-digit BCD up/down timer with key-in, start/pause FSM and registered 7-segment outputs.
// Latency: load -> bcd_out +1 cycle, seg_out +2; running/done lag state by one cycle; no backpressure.
module bcd_timer_7seg
   import timer_pkg::*;
#(
   parameter int DIGITS         = 2,
   parameter int CLK_HZ         = 50_000_000,
   parameter int TICK_HZ        = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset,
   input  logic [3:0]            chave_in,
   input  logic                  load,
   input  logic                  start_in,
   input  logic                  mode_up,
   output logic [8*DIGITS-1:0]   seg_out,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  running,
   output logic                  done
);

   localparam int                  DIV       = div_of(CLK_HZ, TICK_HZ);
   localparam int                  PW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]       PRESC_MAX = PW'(DIV - 1);
   localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'd9}};
   localparam logic [7:0]          SEG_ZERO  = (SEG_ACTIVE_LOW != 0) ? ~SEG_0 : SEG_0;
   localparam logic [8*DIGITS-1:0] SEG_RST   = {DIGITS{SEG_ZERO}};

   state_t                r_state;
   logic [4*DIGITS-1:0]   r_bcd;
   logic [PW-1:0]         r_presc;
   logic                  r_start_q;
   logic                  r_mode_up;
   logic [8*DIGITS-1:0]   r_seg;
   logic                  r_running;
   logic                  r_done;

   logic                  w_edge;
   logic                  w_tick;
   logic [3:0]            w_digit;
   logic [4*DIGITS-1:0]   w_shifted;
   logic [4*DIGITS-1:0]   w_stepped;
   logic                  w_carry;
   logic [8*DIGITS-1:0]   w_seg;

   function automatic logic is_terminal(input logic [4*DIGITS-1:0] bcd, input logic up);
      return up ? (bcd == ALL_NINES) : (bcd == '0);
   endfunction

   assign w_edge  = start_in & ~r_start_q;
   assign w_tick  = (r_presc == PRESC_MAX);
   assign w_digit = (chave_in > 4'd9) ? 4'd9 : chave_in;

   always_comb begin
      w_shifted = r_bcd;
      for (int k = DIGITS - 1; k > 0; k--) begin
         w_shifted[4*k +: 4] = r_bcd[4*(k-1) +: 4];
      end
      w_shifted[3:0] = w_digit;
   end

   // Ripple carry/borrow: a digit wraps 9->0 (up) or 0->9 (down) and passes the carry on.
   always_comb begin
      w_stepped = r_bcd;
      w_carry   = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (w_carry) begin
            if (r_mode_up) begin
               if (r_bcd[4*k +: 4] == 4'd9) begin
                  w_stepped[4*k +: 4] = 4'd0;
               end else begin
                  w_stepped[4*k +: 4] = r_bcd[4*k +: 4] + 4'd1;
                  w_carry             = 1'b0;
               end
            end else begin
               if (r_bcd[4*k +: 4] == 4'd0) begin
                  w_stepped[4*k +: 4] = 4'd9;
               end else begin
                  w_stepped[4*k +: 4] = r_bcd[4*k +: 4] - 4'd1;
                  w_carry             = 1'b0;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
         .i_bcd (r_bcd[4*g +: 4]),
         .o_seg (w_seg[8*g +: 8])
      );
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_state   <= IDLE;
         r_bcd     <= '0;
         r_presc   <= '0;
         r_start_q <= 1'b0;
         r_mode_up <= 1'b0;
         r_seg     <= SEG_RST;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_start_q <= start_in;
         r_running <= (r_state == RUN);
         r_done    <= (r_state == DONE);
         r_seg     <= w_seg;
         // load outranks edge everywhere; edge outranks tick in RUN
         case (r_state)
            IDLE: begin
               if (load) begin
                  r_bcd <= w_shifted;
               end else if (w_edge) begin
                  r_mode_up <= mode_up;
                  r_presc   <= '0;
                  r_state   <= is_terminal(r_bcd, mode_up) ? DONE : RUN;
               end
            end
            RUN: begin
               if (w_edge) begin
                  r_state <= PAUSE;
               end else if (w_tick) begin
                  r_presc <= '0;
                  r_bcd   <= w_stepped;
                  if (is_terminal(w_stepped, r_mode_up)) r_state <= DONE;
               end else begin
                  r_presc <= r_presc + 1'b1;
               end
            end
            PAUSE: begin
               if (load) begin
                  r_bcd   <= w_shifted;
                  r_presc <= '0;
               end else if (w_edge) begin
                  r_state   <= RUN;
                  r_mode_up <= mode_up;
               end
            end
            DONE: begin
               if (load) begin
                  r_bcd   <= w_shifted;
                  r_state <= IDLE;
               end else if (w_edge) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign seg_out = r_seg;
   assign bcd_out = r_bcd;
   assign running = r_running;
   assign done    = r_done;

endmodule

// File: tb/tb_bcd_timer_7seg.sv
// Scoreboard bench for bcd_timer_7seg: an integer-count reference model predicts each cycle's outputs.
module tb_bcd_timer_7seg;

   localparam int D    = 3;
   localparam int DIV  = 10;
   localparam int MAXC = 10**D - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       chave;
   logic             ld;
   logic             st;
   logic             md;
   logic [8*D-1:0]   seg_out;
   logic [4*D-1:0]   bcd_out;
   logic             running;
   logic             done;

   always #5 clk = ~clk;

   bcd_timer_7seg #(
      .DIGITS(D), .CLK_HZ(10), .TICK_HZ(1), .SEG_ACTIVE_LOW(1)
   ) dut (
      .clk_clk     (clk),
      .reset_reset (rst),
      .chave_in    (chave),
      .load        (ld),
      .start_in    (st),
      .mode_up     (md),
      .seg_out     (seg_out),
      .bcd_out     (bcd_out),
      .running     (running),
      .done        (done)
   );

   typedef struct {
      logic [4*D-1:0] bcd;
      logic           run;
      logic           dn;
      logic [8*D-1:0] seg;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // active-low patterns for digits 0..9
   logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   // model: 0 idle, 1 run, 2 pause, 3 done
   int m_state = 0;
   int m_count = 0;
   int m_presc = 0;
   bit m_startq = 1'b0;
   bit m_mode = 1'b0;

   function automatic logic [4*D-1:0] bcd_of(input int c);
      logic [4*D-1:0] r;
      int v;
      r = '0;
      v = c;
      for (int k = 0; k < D; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [8*D-1:0] seg_of(input int c);
      logic [8*D-1:0] r;
      int v;
      r = '0;
      v = c;
      for (int k = 0; k < D; k++) begin
         r[8*k +: 8] = seg_lut[v % 10];
         v = v / 10;
      end
      return r;
   endfunction

   function automatic bit terminal(input int c, input bit up);
      return up ? (c == MAXC) : (c == 0);
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, got, want, $time);
      end
   endtask

   // One clock cycle: drive inputs, advance the model, queue the outputs expected after the edge.
   task automatic cyc(input bit r, input bit l, input logic [3:0] ch, input bit s, input bit m);
      exp_t e;
      bit   edge_s;
      int   dig;
      rst = r; ld = l; chave = ch; st = s; md = m;
      e.run = (m_state == 1);
      e.dn  = (m_state == 3);
      e.seg = seg_of(m_count);
      dig   = (ch > 9) ? 9 : int'(ch);
      if (r) begin
         m_state = 0; m_count = 0; m_presc = 0; m_startq = 0; m_mode = 0;
         e.run = 0; e.dn = 0; e.seg = seg_of(0);
      end else begin
         edge_s   = s && !m_startq;
         m_startq = s;
         case (m_state)
            0: begin
               if (l) m_count = (m_count * 10 + dig) % (MAXC + 1);
               else if (edge_s) begin
                  m_mode  = m;
                  m_presc = 0;
                  m_state = terminal(m_count, m) ? 3 : 1;
               end
            end
            1: begin
               if (edge_s) m_state = 2;
               else if (m_presc == DIV - 1) begin
                  m_presc = 0;
                  m_count = m_mode ? (m_count + 1) % (MAXC + 1) : (m_count + MAXC) % (MAXC + 1);
                  if (terminal(m_count, m_mode)) m_state = 3;
               end else m_presc++;
            end
            2: begin
               if (l) begin
                  m_count = (m_count * 10 + dig) % (MAXC + 1);
                  m_presc = 0;
               end else if (edge_s) begin
                  m_state = 1;
                  m_mode  = m;
               end
            end
            default: begin
               if (l) begin
                  m_count = (m_count * 10 + dig) % (MAXC + 1);
                  m_state = 0;
               end else if (edge_s) m_state = 0;
            end
         endcase
      end
      e.bcd = bcd_of(m_count);
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n, input bit m);
      for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 0, m);
   endtask

   task automatic key(input logic [3:0] d);
      cyc(0, 1, d, 0, 0);
   endtask

   task automatic press(input bit m, input int hold);
      for (int i = 0; i < hold; i++) cyc(0, 0, 4'd0, 1, m);
      cyc(0, 0, 4'd0, 0, m);
   endtask

   task automatic run_to_presc(input int p, input bit m);
      for (int i = 0; i < 4 * DIV && !(m_state == 1 && m_presc == p); i++) cyc(0, 0, 4'd0, 0, m);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("bcd_out", 64'(bcd_out), 64'(e.bcd));
            chk("running", 64'(running), 64'(e.run));
            chk("done",    64'(done),    64'(e.dn));
            chk("seg_out", 64'(seg_out), 64'(e.seg));
         end
      end
   end

   initial begin : stim
      bit s_lvl;
      rst = 1'b1; ld = 1'b0; chave = 4'd0; st = 1'b0; md = 1'b0;
      #2;
      for (int i = 0; i < 3; i++) cyc(1, 0, 4'd0, 0, 0);
      idle(2, 0);
      // key-in and clamp
      key(4'd4); key(4'd7); idle(2, 0); key(4'd12); idle(2, 0);
      // count down 003 -> 000 then DONE, start held several cycles
      cyc(1, 0, 4'd0, 0, 0);
      key(4'd3); idle(1, 0);
      press(0, 4); idle(40, 0);
      press(0, 1); idle(2, 1);
      // up carry 019 -> 020, pause at prescaler 6, hold, resume
      key(4'd1); key(4'd9);
      press(1, 3); idle(12, 1);
      run_to_presc(6, 1); press(1, 1); idle(20, 1);
      press(1, 1); idle(6, 1);
      // tick coinciding with start edge
      run_to_presc(DIV - 1, 1); press(1, 1); idle(3, 1);
      // load and edge together in PAUSE, then in IDLE
      cyc(0, 1, 4'd5, 1, 1); idle(3, 1);
      cyc(1, 0, 4'd0, 0, 0);
      cyc(0, 1, 4'd2, 1, 0); idle(3, 0);
      // 099 -> 100
      cyc(1, 0, 4'd0, 0, 0);
      key(4'd9); key(4'd9); press(1, 1); idle(12, 1);
      // reset mid-run
      cyc(1, 0, 4'd0, 0, 0);
      key(4'd5); key(4'd7); press(1, 1); idle(5, 1);
      cyc(1, 0, 4'd0, 0, 1); idle(3, 1);
      // randomized phase
      s_lvl = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 29) == 0) s_lvl = ~s_lvl;
         cyc(($urandom_range(0, 799) == 0), ($urandom_range(0, 24) == 0),
             4'($urandom_range(0, 15)), s_lvl, 1'($urandom_range(0, 1)));
      end
      @(posedge clk);
      #3;
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
